// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// default memory wait, PC step and branch offset scaling.
package instr_fetch_unit_pkg;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_VALID = 1'b1
    } fetch_state_e;

    localparam int DEFAULT_MEM_WAIT = 2;
    localparam int WAIT_CNT_W       = 4;
    localparam int PC_INCR          = 4;
    localparam int BRANCH_SHIFT     = 2;

    // Branch is taken on an unconditional branch, or a conditional one whose ALU result is zero.
    function automatic logic is_taken(input logic branch, input logic uncondbranch, input logic zero);
        return uncondbranch | (branch & zero);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC: sequential step or word-scaled branch offset,
// wrapping modulo 2^PC_W.
module next_pc_calc
    import instr_fetch_unit_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic [PC_W-1:0] i_sign_ext_imm64,
    input  logic            i_branch,
    input  logic            i_uncondbranch,
    input  logic            i_zero,
    output logic [PC_W-1:0] o_next_pc
);

    logic [PC_W-1:0] w_offset;

    // Select the PC offset and form the next PC.
    always_comb begin
        w_offset = PC_W'(PC_INCR);
        if (is_taken(i_branch, i_uncondbranch, i_zero)) begin
            w_offset = i_sign_ext_imm64 << BRANCH_SHIFT;
        end else begin
            w_offset = PC_W'(PC_INCR);
        end
        o_next_pc = i_pc + w_offset;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: waits MEM_WAIT cycles per address, latches the word
// into the IR, and holds it until decode accepts, then advances the PC.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int MEM_WAIT = DEFAULT_MEM_WAIT,
    parameter int PC_W     = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [PC_W-1:0] i_start_pc,
    output logic [PC_W-1:0] o_instr_addr,
    input  logic [31:0]     i_instr_data,
    output logic [31:0]     o_instr,
    output logic [PC_W-1:0] o_instr_pc,
    output logic            o_fetch_valid,
    input  logic            i_decode_ready,
    input  logic            i_branch,
    input  logic            i_uncondbranch,
    input  logic            i_zero,
    input  logic [PC_W-1:0] i_sign_ext_imm64,
    output logic [31:0]     o_fetch_count
);

    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(MEM_WAIT - 1);

    fetch_state_e          r_state;
    fetch_state_e          w_state_nxt;
    logic [PC_W-1:0]       r_pc;
    logic [PC_W-1:0]       w_pc_nxt;
    logic [PC_W-1:0]       w_next_pc;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_cnt_nxt;
    logic [31:0]           r_instr;
    logic [31:0]           w_instr_nxt;
    logic [PC_W-1:0]       r_instr_pc;
    logic [PC_W-1:0]       w_instr_pc_nxt;
    logic [31:0]           r_fetch_count;
    logic [31:0]           w_fetch_count_nxt;
    logic                  w_accept;

    // Branch controls matter only in the accept cycle, where r_pc is advanced.
    next_pc_calc #(.PC_W(PC_W)) u_next_pc_calc (
        .i_pc             (r_pc),
        .i_sign_ext_imm64 (i_sign_ext_imm64),
        .i_branch         (i_branch),
        .i_uncondbranch   (i_uncondbranch),
        .i_zero           (i_zero),
        .o_next_pc        (w_next_pc)
    );

    assign w_accept = (r_state == ST_VALID) & i_decode_ready;

    // Next-state logic for the fetch/hold FSM and its datapath registers.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        w_fetch_count_nxt = r_fetch_count;
        case (r_state)
            ST_FETCH: begin
                if (r_wait_cnt == LAST_WAIT) begin
                    w_instr_nxt    = i_instr_data;
                    w_instr_pc_nxt = r_pc;
                    w_state_nxt    = ST_VALID;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_CNT_W'(1);
                end
            end
            ST_VALID: begin
                if (w_accept) begin
                    w_pc_nxt          = w_next_pc;
                    w_wait_cnt_nxt    = '0;
                    w_fetch_count_nxt = r_fetch_count + 32'd1;
                    w_state_nxt       = ST_FETCH;
                end else begin
                    w_state_nxt = ST_VALID;
                end
            end
            default: begin
                w_state_nxt    = ST_FETCH;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight fetch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_FETCH;
            r_pc          <= i_start_pc;
            r_wait_cnt    <= '0;
            r_instr       <= 32'd0;
            r_instr_pc    <= '0;
            r_fetch_count <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    assign o_instr_addr  = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_fetch_valid = (r_state == ST_VALID);
    assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed instruction stream with a
// latency-modelled instruction memory and a negedge monitor.
module tb_instr_fetch_unit;

    localparam int MEM_WAIT = 2;
    localparam int PC_W     = 64;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] start_pc = 64'd0;
    logic [63:0] instr_addr;
    logic [31:0] instr_data;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        fetch_valid;
    logic        decode_ready = 1'b0;
    logic        branch = 1'b0;
    logic        uncondbranch = 1'b0;
    logic        zero = 1'b0;
    logic [63:0] imm = 64'd0;
    logic [31:0] fetch_count;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] pc_model = 64'd0;
    logic [31:0] cnt_model = 32'd0;
    logic [31:0] noise = 32'd0;
    int          age = 0;
    logic [63:0] last_addr = 64'd0;

    instr_fetch_unit #(.MEM_WAIT(MEM_WAIT), .PC_W(PC_W)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_start_pc       (start_pc),
        .o_instr_addr     (instr_addr),
        .i_instr_data     (instr_data),
        .o_instr          (instr),
        .o_instr_pc       (instr_pc),
        .o_fetch_valid    (fetch_valid),
        .i_decode_ready   (decode_ready),
        .i_branch         (branch),
        .i_uncondbranch   (uncondbranch),
        .i_zero           (zero),
        .i_sign_ext_imm64 (imm),
        .o_fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'd0) return 32'hF840_03E9;
        else            return a[63:32] ^ a[31:0] ^ 32'h1234_5678;
    endfunction

    // Memory returns garbage until the address has been stable long enough.
    always @(negedge clk) begin
        if (rst || instr_addr != last_addr) age <= 0;
        else if (age < 100)                 age <= age + 1;
        last_addr <= instr_addr;
    end
    assign instr_data = (age >= MEM_WAIT - 1) ? (mem_word(instr_addr) ^ noise) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every cycle the IR is valid it must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && fetch_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {32'd0, instr}, 64'd0 - 64'd1);
            end else begin
                check("instr",       {32'd0, instr},       {32'd0, exp_q[0].instr});
                check("instr_pc",    instr_pc,             exp_q[0].pc);
                check("instr_addr",  instr_addr,           exp_q[0].pc);
                check("fetch_count", {32'd0, fetch_count}, {32'd0, exp_q[0].cnt});
                if (decode_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic set_decoys();
        branch = 1'b1; uncondbranch = 1'b1; zero = 1'b1; imm = 64'h0000_0000_0000_0123;
    endtask

    task automatic apply_reset(input logic [63:0] start);
        start_pc = start;
        #1 rst = 1'b1;
        #1;
        check("rst_instr_addr",   instr_addr,           start);
        check("rst_fetch_valid",  {63'd0, fetch_valid}, 64'd0);
        check("rst_instr",        {32'd0, instr},       64'd0);
        check("rst_instr_pc",     instr_pc,             64'd0);
        check("rst_fetch_count",  {32'd0, fetch_count}, 64'd0);
        exp_q.delete();
        pc_model  = start;
        cnt_model = 32'd0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_valid(output int waited);
        waited = 0;
        while (!fetch_valid && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        check("fetch_latency", 64'(waited), 64'(MEM_WAIT));
    endtask

    task automatic do_instr(input logic br, input logic ub, input logic z,
                            input logic [63:0] off, input int stall, input logic [63:0] exp_next);
        exp_t e;
        int   waited;
        e.pc = pc_model; e.instr = mem_word(pc_model); e.cnt = cnt_model;
        exp_q.push_back(e);
        set_decoys();
        decode_ready = 1'b1;
        wait_valid(waited);
        if (!fetch_valid) return;
        if (stall > 0) begin
            decode_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                noise = $urandom | 32'd1;
                @(posedge clk); #1;
            end
        end
        noise = 32'd0;
        branch = br; uncondbranch = ub; zero = z; imm = off;
        decode_ready = 1'b1;
        @(posedge clk); #1;
        check("next_addr",       instr_addr,           exp_next);
        check("count_after",     {32'd0, fetch_count}, {32'd0, cnt_model + 32'd1});
        check("valid_after_acc", {63'd0, fetch_valid}, 64'd0);
        pc_model  = exp_next;
        cnt_model = cnt_model + 32'd1;
        set_decoys();
    endtask

    initial begin
        exp_t e;
        int   waited;
        #100000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   waited;
        set_decoys();
        apply_reset(64'd0);
        do_instr(1'b0, 1'b0, 1'b0, 64'd0, 0, 64'h4);
        do_instr(1'b0, 1'b0, 1'b0, 64'd0, 0, 64'h8);
        do_instr(1'b0, 1'b0, 1'b0, 64'd0, 0, 64'hC);
        do_instr(1'b0, 1'b0, 1'b0, 64'd0, 0, 64'h10);
        do_instr(1'b0, 1'b0, 1'b0, 64'd0, 0, 64'h14);
        do_instr(1'b0, 1'b0, 1'b0, 64'd0, 0, 64'h18);
        do_instr(1'b0, 1'b0, 1'b0, 64'd0, 0, 64'h1C);
        do_instr(1'b1, 1'b0, 1'b0, 64'd4, 0, 64'h20);
        do_instr(1'b0, 1'b0, 1'b0, 64'd0, 0, 64'h24);
        do_instr(1'b0, 1'b0, 1'b0, 64'd0, 0, 64'h28);
        do_instr(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 0, 64'h1C);
        do_instr(1'b1, 1'b0, 1'b1, 64'd4, 0, 64'h2C);
        do_instr(1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 5, 64'h28);
        do_instr(1'b0, 1'b0, 1'b1, 64'd100, 0, 64'h2C);

        // Reset while an instruction is held in VALID.
        e.pc = pc_model; e.instr = mem_word(pc_model); e.cnt = cnt_model;
        exp_q.push_back(e);
        decode_ready = 1'b0;
        wait_valid(waited);
        @(posedge clk); #1;
        apply_reset(64'h14);

        // Reset one cycle into FETCH.
        @(posedge clk); #1;
        apply_reset(64'h14);
        do_instr(1'b0, 1'b0, 1'b0, 64'd0, 0, 64'h18);

        apply_reset(64'hFFFF_FFFF_FFFF_FFFC);
        do_instr(1'b0, 1'b0, 1'b0, 64'd0, 0, 64'h0);
        do_instr(1'b0, 1'b0, 1'b0, 64'd0, 0, 64'h4);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
